crc32_chk: RTL

CRC32_CHK -- requirements
Module: crc32_chk

---
 rtl/crc32_chk_pkg.sv | 34 +++
 rtl/crc32_fold32.sv | 14 +
 rtl/crc32_chk.sv | 134 +++++++++++++
 3 files changed

// File: rtl/crc32_chk_pkg.sv
// Shared CRC-32 (PNG) constants, checker FSM encoding and word-fold function.
// Used by crc32_chk and reusable by the matching crc32 generator.
package crc32_chk_pkg;

    localparam int unsigned CRC_W    = 32;
    localparam int unsigned ERRCNT_W = 16;
    localparam int unsigned ST_W     = 2;

    localparam logic [CRC_W-1:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [CRC_W-1:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [CRC_W-1:0] CRC_XOROUT = 32'hFFFF_FFFF;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_DATA = 2'd1;
    localparam logic [ST_W-1:0] ST_CHK  = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

    // Reflected CRC update over one word, byte [31:24] first, each byte LSB first.
    function automatic logic [CRC_W-1:0] crc32_fold_word(
        input logic [CRC_W-1:0] crc,
        input logic [CRC_W-1:0] dat
    );
        logic [CRC_W-1:0] c;
        c = crc;
        for (int b = 3; b >= 0; b--) begin
            c = c ^ {24'd0, dat[8*b +: 8]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_fold32.sv
// Combinational single-word CRC-32 fold, shared between checker and generator.
module crc32_fold32
    import crc32_chk_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [CRC_W-1:0] dat,
    output logic [CRC_W-1:0] crc_out
);

    always_comb begin
        crc_out = crc32_fold_word(crc_in, dat);
    end

endmodule

// File: rtl/crc32_chk.sv
// PNG chunk CRC-32 checker: folds covered words, compares the trailing stored CRC.
// Optional saturating error counter output enabled by macro CRC32_CHK_ERRCNT_EN.
module crc32_chk
    import crc32_chk_pkg::*;
#(
    parameter int unsigned DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    output logic               done_o,
    output logic               ok_o,
    output logic               err_o,
    output logic [DATA_WD-1:0] crc_o
`ifdef CRC32_CHK_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt_o
`endif
);

    logic [ST_W-1:0]  r_state;
    logic [CRC_W-1:0] r_crc;
    logic             r_done;
    logic             r_ok;
    logic             r_err;
    logic [CRC_W-1:0] r_crc_out;

    logic [ST_W-1:0]  w_state_nxt;
    logic [CRC_W-1:0] w_crc_nxt;
    logic [CRC_W-1:0] w_crc_fold;
    logic             w_fin;
    logic             w_match;

    crc32_fold32 u_fold (
        .crc_in  (r_crc),
        .dat     (dat_i),
        .crc_out (w_crc_fold)
    );

    assign w_match = (dat_i == (r_crc ^ CRC_XOROUT));

    // State and running CRC register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_crc   <= CRC_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_crc   <= w_crc_nxt;
        end
    end

    // Next state; start_i aborts any chunk in flight and drops a coincident word
    always_comb begin
        w_state_nxt = r_state;
        w_crc_nxt   = r_crc;
        w_fin       = 1'b0;
        if (start_i) begin
            w_state_nxt = ST_DATA;
            w_crc_nxt   = CRC_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_DATA: begin
                    if (val_i) begin
                        w_crc_nxt = w_crc_fold;
                        if (lst_i) begin
                            w_state_nxt = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (val_i) begin
                        w_state_nxt = ST_DONE;
                        w_fin       = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Result registers; crc_o keeps the last result until a new check completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_crc_out <= '0;
        end else if (start_i) begin
            r_done <= 1'b0;
            r_ok   <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_fin) begin
            r_done    <= 1'b1;
            r_ok      <= w_match;
            r_err     <= !w_match;
            r_crc_out <= r_crc ^ CRC_XOROUT;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign done_o = r_done;
    assign ok_o   = r_ok;
    assign err_o  = r_err;
    assign crc_o  = r_crc_out;

`ifdef CRC32_CHK_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_cnt;

    // Saturating count of failed checks, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= '0;
        end else if (w_fin && !start_i && !w_match && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule
